// File: rtl/pipe_latch_elastic.sv
`timescale 1ns/1ps
// pipe_latch_elastic
//   A single elastic pipeline stage with two entries: a head register (m)
//   and a skid register (s), both of which hold payloads in FIFO order. With
//   a skid entry, the stage sustains one payload per cycle while out_ready
//   is high. Backpressure is absorbed for one extra payload before in_ready
//   drops. No combinational path runs from in_data to out_data, so a payload
//   always takes at least one cycle to pass through.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   upstream payload valid
//   in_data    upstream payload [N-1:0]
//   in_ready   stage can accept in_data this cycle
//   out_valid  out_data is valid this cycle
//   out_data   oldest held payload (head register)
//   out_ready  downstream accepts out_data
//   stall      freeze the stage; no handshakes on either side
//   squash     discard every held payload; wins over stall and handshakes
//   count      number of held payloads, 0..2 (also the stage's state)
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// exactly when valid and ready are both high in the cycle before that edge.
// valid never depends on ready. While out_valid is high and out_ready is
// low, out_data holds steady. in_data and in_valid are ignored while
// in_ready is low.
module pipe_latch_elastic #(
  parameter int              N      = 32,
  parameter logic [N-1:0]    BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  input  logic         stall,
  input  logic         squash,
  output logic [1:0]   count
);

  logic [N-1:0] m_q, m_nxt;
  logic [N-1:0] s_q, s_nxt;
  logic [1:0]   cnt_q, cnt_nxt;
  logic         in_fire;
  logic         out_fire;

  // in_ready is also held low during reset, so the reset condition
  // appears on the upstream side as well.
  assign in_ready  = rst & (cnt_q != 2'd2) & ~stall & ~squash;
  assign out_valid = (cnt_q != 2'd0) & ~stall & ~squash;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = m_q;
  assign count     = cnt_q;

  always_comb begin
    m_nxt   = m_q;
    s_nxt   = s_q;
    cnt_nxt = cnt_q;
    if (squash) begin
      m_nxt   = BUBBLE;
      s_nxt   = BUBBLE;
      cnt_nxt = 2'd0;
    end else if (!stall) begin
      // Both fire signals are already low under stall. This guard exists
      // only to make the freeze explicit.
      case (cnt_q)
        2'd0: begin
          if (in_fire) begin
            m_nxt   = in_data;
            cnt_nxt = 2'd1;
          end
        end
        2'd1: begin
          if (in_fire && out_fire) begin
            // The head leaves and the new payload replaces it; skid stays empty.
            m_nxt = in_data;
          end else if (in_fire) begin
            s_nxt   = in_data;
            cnt_nxt = 2'd2;
          end else if (out_fire) begin
            m_nxt   = BUBBLE;
            cnt_nxt = 2'd0;
          end
        end
        2'd2: begin
          // The stage is full, so in_ready is low and only a pop can happen.
          if (out_fire) begin
            m_nxt   = s_q;
            s_nxt   = BUBBLE;
            cnt_nxt = 2'd1;
          end
        end
        default: begin
          // Unreachable encoding. Recover to empty.
          m_nxt   = BUBBLE;
          s_nxt   = BUBBLE;
          cnt_nxt = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   <= BUBBLE;
      s_q   <= BUBBLE;
      cnt_q <= 2'd0;
    end else begin
      m_q   <= m_nxt;
      s_q   <= s_nxt;
      cnt_q <= cnt_nxt;
    end
  end

endmodule
